result_seg7_display: RTL and testbench
======================================

Name: result_seg7_display

Overview:
- Consumer end of the core's 32-bit Result bus: captures Result and shows it as 8 hex digits on the board's multiplexed 7-segment display (LED segments, Anode digit enables).
- Sits at the top level between RV32I and the board pins, making Result visible on hardware.
- Contains a refresh divider, a digit-scan counter, a hold/capture register and leading-zero blanking.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit; legal range 1..2^20.
- BLANK_LZ, 1: 1 = blank leading-zero digits; 0 = always show all 8 digits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- Result  input  32  value to display (RV32I output)
- hold  input  1  1 = freeze the displayed value; 0 = track Result
- LED  output  7  segment drives, active-low; bit0=a, bit1=b, … bit6=g
- Anode  output  8  digit enables, active-low; bit i = hex nibble i (bit0 = least significant)

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-low: rst=0 immediately clears all state. No synchronous clear.
- Reset values:
  - disp_q = 0, div_cnt = 0, idx = 0.
  - LED = 7'h7F (all segments off), Anode = 8'hFF (all digits off).
  - These values hold while rst=0, including assertion mid-scan.
- Capture:
  - Each rising edge with hold=0: disp_q <= Result.
  - hold=1: disp_q unchanged.
  - 1-cycle latency from Result to disp_q.
  - hold sampled every cycle; no hysteresis.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1: div_cnt wraps to 0 and idx <= idx+1 mod 8 (7 wraps to 0).
  - REFRESH_DIV=1: idx advances every cycle.
- Output stage:
  - LED and Anode are registered.
  - Computed from the current idx and disp_q, so they lag idx/disp_q by 1 cycle.
  - Full scan period = 8*REFRESH_DIV cycles.
- Digit decode:
  - nib = disp_q[4*idx+3 : 4*idx]; LED = seg(nib).
  - Anode = all ones except bit idx = 0.
- Segment table (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Leading-zero blanking:
  - Condition: BLANK_LZ=1, idx≠0, and nibbles idx..7 of disp_q are all zero.
  - Then the slot is blank: Anode=8'hFF, LED=7'h7F.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Internal zeros are never blanked; e.g. 0x00A0_00F0 shows "A0 00F0" with digits 7–6 blank.
- Simultaneous events:
  - Capture and idx advance on the same edge: the output register on the next edge uses the new idx and new disp_q.
  - No tearing guarantee across a scan; a value change mid-scan shows mixed digits for at most one scan period.
  - hold=1 avoids this.
- Widths:
  - div_cnt width = clog2(REFRESH_DIV), minimum 1.
  - idx is 3 bits.
  - No arithmetic overflow paths beyond the defined wraps.

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF = 7'h7F, AN_OFF = 8'hFF.
  - The 16-entry hex-to-segment constant table.
  - NUM_DIGITS = 8.
- One sub-module, hex_to_seg7: combinational nibble-to-segment decoder using the package table. Instantiated once, muxed by idx.
- Divider, scan counter, capture register and blanking logic stay in result_seg7_display.

Test Plan:
1. Reset:
   - Hold rst=0 for 10 cycles with Result=32'h12345678.
   - Release, then assert rst=0 mid-scan (idx=5).
   - Expect LED=7F and Anode=FF throughout both rst=0 windows, with asynchronous response to the mid-scan assertion.
2. Full scan, no blanking (REFRESH_DIV=4, BLANK_LZ=0, Result=32'h89ABCDEF):
   - Over 32 cycles, Anode steps FE,FD,FB,…,7F, each held 4 cycles.
   - LED = 0E,06,21,46,03,08,10,00 in order, then idx wraps to 0 (Anode FE).
3. Leading-zero blanking (BLANK_LZ=1, Result=32'h000000A0):
   - Digits 0 and 1 show 40 and 08 with Anode FE and FD.
   - Slots 2–7 give Anode=FF, LED=7F.
   - Result=0: only digit 0 lights, LED=40.
4. Hold:
   - Result=32'h11111111, then hold=1, then Result=32'h22222222 for 3 scans.
   - Every lit digit shows LED=79.
   - Release hold: within 1 scan every digit shows LED=24.
5. REFRESH_DIV=1:
   - idx advances every clk.
   - Anode sequence FE,FD,FB,F7,EF,DF,BF,7F repeats with period 8.
   - Output lags the idx change by exactly 1 cycle.

Source files
------------

// File: rtl/result_seg7_display_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment display:
// blank encodings, digit count and the active-low hex segment table.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/result_seg7_display_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[nib_i];
  end

endmodule

// File: rtl/result_seg7_display.sv
// Captures the 32-bit Result bus and scans it as 8 hex digits onto a
// multiplexed active-low 7-segment display with optional leading-zero blanking.
module result_seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Result,
  input  logic        hold,
  output logic [6:0]  LED,
  output logic [7:0]  Anode
);

  localparam int unsigned     DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [31:0]      disp_q, disp_d;
  logic [6:0]       led_q, led_d;
  logic [7:0]       anode_q, anode_d;

  logic [3:0]       nib;
  logic [6:0]       seg;
  logic [31:0]      upper_nibs;
  logic             blank;

  hex_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (seg)
  );

  always_comb begin
    disp_d    = hold ? disp_q : Result;
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end
  end

  // A slot is blank when it and every more-significant nibble are zero.
  always_comb begin
    nib        = disp_q[{idx_q, 2'b00} +: 4];
    upper_nibs = disp_q >> {idx_q, 2'b00};
    blank      = BLANK_LZ && (idx_q != 3'd0) && (upper_nibs == '0);
    led_d      = seg;
    anode_d    = ~(8'h01 << idx_q);
    if (blank) begin
      led_d   = SEG_OFF;
      anode_d = AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      led_q     <= SEG_OFF;
      anode_q   <= AN_OFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      led_q     <= led_d;
      anode_q   <= anode_d;
    end
  end

  assign LED   = led_q;
  assign Anode = anode_q;

endmodule

// File: tb/tb_result_seg7_display.sv
// Self-checking bench: three display instances (div 4 no blanking, div 4
// blanking, div 1 blanking) compared against a cycle-count reference model.
module tb_result_seg7_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Result = '0;
  logic        hold = 1'b0;

  logic [6:0] led_a, led_b, led_c;
  logic [7:0] an_a, an_b, an_c;
  logic [6:0] d_led [3];
  logic [7:0] d_an  [3];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  localparam int unsigned CFG_DIV [3] = '{4, 4, 1};
  localparam bit          CFG_BLZ [3] = '{1'b0, 1'b1, 1'b1};

  logic [6:0] seg_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [7:0] an_seq  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] led_seq [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

  result_seg7_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .Result(Result), .hold(hold), .LED(led_a), .Anode(an_a));
  result_seg7_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .Result(Result), .hold(hold), .LED(led_b), .Anode(an_b));
  result_seg7_display #(.REFRESH_DIV(1), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .Result(Result), .hold(hold), .LED(led_c), .Anode(an_c));

  assign d_led[0] = led_a;
  assign d_led[1] = led_b;
  assign d_led[2] = led_c;
  assign d_an[0]  = an_a;
  assign d_an[1]  = an_b;
  assign d_an[2]  = an_c;

  always #5 clk = ~clk;

  // Reference: after n edges since reset the scan slot is (n/div) mod 8;
  // the registered output at edge n+1 shows that slot of the value captured so far.
  int unsigned m_edges;
  logic [31:0] m_disp;
  logic [6:0]  exp_led [3];
  logic [7:0]  exp_an  [3];

  function automatic logic [14:0] ref_out(int unsigned div, bit blz,
                                          int unsigned edges, logic [31:0] d);
    int unsigned idx;
    logic [31:0] up;
    idx = (edges / div) % 8;
    up  = d >> (4 * idx);
    if (blz && idx != 0 && up == 0) return {8'hFF, 7'h7F};
    return {~(8'h01 << idx), seg_tbl[up[3:0]]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edges <= 0;
      m_disp  <= '0;
      for (int i = 0; i < 3; i++) begin
        exp_led[i] <= 7'h7F;
        exp_an[i]  <= 8'hFF;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        {exp_an[i], exp_led[i]} <= ref_out(CFG_DIV[i], CFG_BLZ[i], m_edges, m_disp);
      end
      m_disp  <= hold ? m_disp : Result;
      m_edges <= m_edges + 1;
    end
  end

  task automatic test_reset();
    Result = 32'h12345678;
    hold   = 1'b0;
    rst    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_led[k] !== 7'h7F || d_an[k] !== 8'hFF) begin
          failures++;
          $display("FAIL reset_hold dut%0d: LED=%h Anode=%h expected LED=7f Anode=ff", k, d_led[k], d_an[k]);
        end
      end
    end
    rst = 1'b1;
    repeat (21) @(negedge clk);
    checks++;
    if (an_a !== 8'hDF) begin
      failures++;
      $display("FAIL reset_prescan: Anode=%h expected df", an_a);
    end
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (d_led[k] !== 7'h7F || d_an[k] !== 8'hFF) begin
        failures++;
        $display("FAIL reset_async dut%0d: LED=%h Anode=%h expected LED=7f Anode=ff", k, d_led[k], d_an[k]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_led[k] !== 7'h7F || d_an[k] !== 8'hFF) begin
          failures++;
          $display("FAIL reset_midscan dut%0d: LED=%h Anode=%h expected LED=7f Anode=ff", k, d_led[k], d_an[k]);
        end
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_full_scan();
    int unsigned idx;
    Result = 32'h89ABCDEF;
    hold   = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      idx = ((m_edges - 1) / 4) % 8;
      checks++;
      if (an_a !== an_seq[idx] || led_a !== led_seq[idx]) begin
        failures++;
        $display("FAIL full_scan slot%0d: LED=%h Anode=%h expected LED=%h Anode=%h",
                 idx, led_a, an_a, led_seq[idx], an_seq[idx]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_led[k] !== exp_led[k] || d_an[k] !== exp_an[k]) begin
          failures++;
          $display("FAIL full_scan_model dut%0d: LED=%h Anode=%h expected LED=%h Anode=%h",
                   k, d_led[k], d_an[k], exp_led[k], exp_an[k]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    int unsigned idx;
    logic [6:0] el;
    logic [7:0] ea;
    Result = 32'h000000A0;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = ((m_edges - 1) / 4) % 8;
      el = (idx == 0) ? 7'h40 : (idx == 1) ? 7'h08 : 7'h7F;
      ea = (idx == 0) ? 8'hFE : (idx == 1) ? 8'hFD : 8'hFF;
      checks++;
      if (led_b !== el || an_b !== ea) begin
        failures++;
        $display("FAIL blank_a0 slot%0d: LED=%h Anode=%h expected LED=%h Anode=%h", idx, led_b, an_b, el, ea);
      end
    end
    Result = 32'h0;
    repeat (40) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      idx = ((m_edges - 1) / 4) % 8;
      el = (idx == 0) ? 7'h40 : 7'h7F;
      ea = (idx == 0) ? 8'hFE : 8'hFF;
      checks++;
      if (led_b !== el || an_b !== ea) begin
        failures++;
        $display("FAIL blank_zero slot%0d: LED=%h Anode=%h expected LED=%h Anode=%h", idx, led_b, an_b, el, ea);
      end
      checks++;
      if (led_a !== 7'h40 || an_a === 8'hFF) begin
        failures++;
        $display("FAIL noblank_zero slot%0d: LED=%h Anode=%h expected LED=40 with a lit digit", idx, led_a, an_a);
      end
    end
  endtask

  task automatic test_hold();
    Result = 32'h11111111;
    hold   = 1'b0;
    repeat (2) @(negedge clk);
    hold   = 1'b1;
    Result = 32'h22222222;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_an[k] === 8'hFF || d_led[k] !== 7'h79) begin
          failures++;
          $display("FAIL hold_frozen dut%0d: LED=%h Anode=%h expected LED=79 lit", k, d_led[k], d_an[k]);
        end
      end
    end
    hold = 1'b0;
    repeat (34) @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_an[k] === 8'hFF || d_led[k] !== 7'h24) begin
          failures++;
          $display("FAIL hold_release dut%0d: LED=%h Anode=%h expected LED=24 lit", k, d_led[k], d_an[k]);
        end
      end
    end
  endtask

  task automatic test_div1();
    @(negedge clk);
    rst    = 1'b0;
    Result = 32'hFFFFFFFF;
    hold   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (an_c !== an_seq[i % 8]) begin
        failures++;
        $display("FAIL div1_anode step%0d: Anode=%h expected %h", i, an_c, an_seq[i % 8]);
      end
      checks++;
      if (led_c !== ((i == 0) ? 7'h40 : 7'h0E)) begin
        failures++;
        $display("FAIL div1_led step%0d: LED=%h expected %h", i, led_c, (i == 0) ? 7'h40 : 7'h0E);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (d_led[k] !== exp_led[k] || d_an[k] !== exp_an[k]) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d: LED=%h Anode=%h expected LED=%h Anode=%h",
                   k, c, d_led[k], d_an[k], exp_led[k], exp_an[k]);
        end
      end
      Result = $urandom >> $urandom_range(0, 31);
      hold   = ($urandom_range(0, 3) == 0);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst = 1'b0;
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_blanking();
    test_hold();
    test_div1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
